// File: rtl/gate_sweep_if.sv
// Control/status and gate-facing bus of the gate truth-table sweeper.
// slave: the sweeper; master: the controller side, which also owns the gate results.
interface gate_sweep_if #(
  parameter int N_IN  = 2,
  parameter int ERR_W = 8
);
  logic              start;
  logic [6:0]        func_mask;
  logic [N_IN-1:0]   dut_in;
  logic [6:0]        dut_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_cnt;
  logic [N_IN-1:0]   first_fail_vec;
  logic [6:0]        first_fail_func;

  modport slave (
    input  start, func_mask, dut_out,
    output dut_in, busy, done, pass, err_cnt, first_fail_vec, first_fail_func
  );

  modport master (
    output start, func_mask, dut_out,
    input  dut_in, busy, done, pass, err_cnt, first_fail_vec, first_fail_func
  );
endinterface

// File: rtl/gate_sweep_bist.sv
// Exhaustive truth-table sweeper for the NOT/NAND/NOR/AND/OR/XOR/XNOR gate set.
// Optional macro GATE_SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatching sample.
module gate_sweep_bist #(
  parameter int N_IN  = 2,
  parameter int DWELL = 4,
  parameter int ERR_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  gate_sweep_if.slave  bus
);

  localparam int          DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [N_IN:0]   VEC_LAST   = (N_IN+1)'((1 << N_IN) - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [N_IN:0]      r_vec_cnt, w_vec_nxt;
  logic [DW_W-1:0]    r_dwell, w_dwell_nxt;
  logic [ERR_W-1:0]   r_err, w_err_nxt;
  logic               r_fail_seen, w_fail_nxt;
  logic [N_IN-1:0]    r_ffv, w_ffv_nxt;
  logic [6:0]         r_fff, w_fff_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;

  logic [N_IN-1:0]    w_v;
  logic [6:0]         w_gold;
  logic [6:0]         w_mm;
  logic               w_cmp;
  logic               w_stop;

  // dut_in comes straight from the vector counter, so it only moves on an advance
  assign w_v = r_vec_cnt[N_IN-1:0];

  assign w_gold[0] = ~w_v[0];
  assign w_gold[1] = ~(&w_v);
  assign w_gold[2] = ~(|w_v);
  assign w_gold[3] = &w_v;
  assign w_gold[4] = |w_v;
  assign w_gold[5] = ^w_v;
  assign w_gold[6] = ~(^w_v);

  assign w_mm  = (bus.dut_out ^ w_gold) & bus.func_mask;
  assign w_cmp = (r_state == SETTLE) && (r_dwell == DWELL_LAST);

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
  assign w_stop = (w_mm != 7'd0);
`else
  assign w_stop = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_vec_cnt   <= '0;
      r_dwell     <= '0;
      r_err       <= '0;
      r_fail_seen <= 1'b0;
      r_ffv       <= '0;
      r_fff       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_vec_cnt   <= w_vec_nxt;
      r_dwell     <= w_dwell_nxt;
      r_err       <= w_err_nxt;
      r_fail_seen <= w_fail_nxt;
      r_ffv       <= w_ffv_nxt;
      r_fff       <= w_fff_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec_cnt;
    w_dwell_nxt = r_dwell;
    w_err_nxt   = r_err;
    w_fail_nxt  = r_fail_seen;
    w_ffv_nxt   = r_ffv;
    w_fff_nxt   = r_fff;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    case (r_state)
      IDLE, DONE: begin
        if (bus.start) begin
          w_state_nxt = SETTLE;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
          w_vec_nxt   = '0;
          w_dwell_nxt = '0;
          w_err_nxt   = '0;
          w_fail_nxt  = 1'b0;
          w_ffv_nxt   = '0;
          w_fff_nxt   = '0;
        end
      end
      SETTLE: begin
        if (!w_cmp) begin
          w_dwell_nxt = r_dwell + 1'b1;
        end else begin
          // one error per sample regardless of how many functions disagree
          if (w_mm != 7'd0) begin
            if (r_err != {ERR_W{1'b1}}) w_err_nxt = r_err + 1'b1;
            if (!r_fail_seen) begin
              w_fail_nxt = 1'b1;
              w_ffv_nxt  = w_v;
              w_fff_nxt  = w_mm;
            end
          end
          if ((r_vec_cnt == VEC_LAST) || w_stop) begin
            w_state_nxt = DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_vec_nxt   = r_vec_cnt + 1'b1;
            w_dwell_nxt = '0;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.dut_in          = w_v;
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.pass            = r_done && (r_err == '0);
  assign bus.err_cnt         = r_err;
  assign bus.first_fail_vec  = r_ffv;
  assign bus.first_fail_func = r_fff;

endmodule
